serial_alu: RTL and testbench
=============================

Name: serial_alu

Overview:
- Bit-serial counterpart of the central unit's parallel ALU.
- Takes WIDTH-bit operands, a function select and a carry-in on a start strobe.
- Processes one bit per clock, LSB first, through a single 1-bit ALU slice and a carry flop.
- Presents a parallel result and per-bit carry vector with a done pulse; used where area matters more than latency.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  operation request, sampled only in IDLE.
- A  input  WIDTH  operand A, captured on accepted start.
- B  input  WIDTH  operand B, captured on accepted start.
- S  input  4  function select, captured on accepted start.
- M  input  1  mode: 1 = logic, 0 = arithmetic; captured.
- Pin  input  1  carry-in for bit 0, arithmetic mode only; captured.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: R/P hold a new result.
- R  output  WIDTH  result, registered.
- P  output  WIDTH  carry-out of each bit position, registered; P[WIDTH-1] is the word carry-out.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, R=0, P=0; shift registers, carry flop and bit counter cleared. Reset mid-operation aborts it; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE + start=1 at an edge:
  - Load A/B shift registers; latch S and M.
  - Carry flop = Pin if M=0, else 0; counter = 0.
  - Go to RUN; busy=1 from that edge.
- RUN, each edge:
  - Compute bit i = counter from a_i = A reg LSB, b_i = B reg LSB, c = carry flop.
  - Shift r_i into the result register MSB-first so that after WIDTH shifts bit 0 lands at position 0.
  - Store cout into the P-accumulator position i; carry flop = cout.
  - Shift A/B right; counter++.
  - The edge processing counter = WIDTH-1 goes to DONE.
- Logic mode (M=1): r_i = S[{a_i,b_i}], 4-entry truth table indexed by 2*a_i+b_i; cout=0. Examples: S=0110 XOR, S=1001 XNOR, S=1000 AND, S=1110 OR, S=0011 NOT A.
- Arithmetic mode (M=0):
  - x = a_i ^ S[2].
  - y = 0 / b_i / ~b_i / 1 for S[1:0] = 00 / 01 / 10 / 11.
  - r_i = x^y^c; cout = majority(x,y,c).
  - S[3] is reserved and ignored.
  - S=0001 Pin=0 is ADD; S=0010 Pin=1 is SUB (A-B, P[WIDTH-1]=1 means no borrow); S=0000 Pin=1 is INC A; S=0011 Pin=0 is DEC A.
- R and P outputs change only on the edge entering DONE and hold the previous result throughout RUN.
- DONE: done=1, busy=0 for exactly one cycle; next edge goes to IDLE unconditionally.
- Start is ignored in RUN and DONE; inputs A/B/S/M/Pin may change freely after acceptance.
- Latency: start accepted at edge k; done high in the cycle after edge k+WIDTH; R/P valid from that edge until the next completed operation. Minimum issue interval WIDTH+2 cycles.
- Arithmetic wraps modulo 2^WIDTH; overflow is visible only via P[WIDTH-1].

Test Plan:
- Reset: rst_n low with start held high -> busy=0, done=0, R=0, P=0; release, start=1 A=3 B=11 S=0001 M=0 Pin=0 -> exactly 4 edges later done=1, R=14, P=0011.
- Wrap: A=15 B=1 S=0001 M=0 Pin=0 -> R=0, P=1111, done one cycle only, then IDLE.
- Subtract: A=9 B=1 S=0010 M=0 Pin=1 -> R=8, P[3]=1; A=1 B=9 same S/Pin -> R=8, P[3]=0.
- Logic: A=10 B=2 S=0110 M=1 Pin=1 -> R=8, P=0000; A=5 B=13 S=1001 M=1 -> R=7.
- Busy protection: start again at cycle 2 of RUN with different operands -> ignored, first result delivered unchanged; R holds its old value until the done edge.
- Reset mid-RUN after 2 bits -> outputs 0 immediately, no done; next operation completes normally with the correct result.

Source files
------------

// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU. Operands are captured on an accepted start,
// then processed LSB first, one bit per clock, through a single 1-bit slice
// and a carry flop. The parallel result and the per-bit carry vector are
// presented together with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  operation request, only looked at in IDLE
//   A, B   WIDTH-bit operands, captured on accepted start
//   S      4-bit function select, captured
//   M      mode: 1 = logic, 0 = arithmetic, captured
//   Pin    carry-in for bit 0 (arithmetic mode only), captured
//   busy   high while an operation is in progress
//   done   one-cycle pulse, R/P hold a new result
//   R      registered result
//   P      registered carry-out of each bit; P[WIDTH-1] is the word carry
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit processed per edge, LSB first
// DONE  | R/P just updated, done pulse for one cycle
module serial_alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       S,
  input  logic             M,
  input  logic             Pin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] P
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr, b_sr, r_sr, p_acc;
  logic [WIDTH-1:0] r_nxt, p_nxt;
  logic [3:0]       s_q;
  logic             m_q;
  logic             c_q;
  logic [CW-1:0]    cnt;

  logic a_i, b_i, x, y, r_i, cout;
  logic accept, last_bit;

  assign accept   = (state == IDLE) && start;
  assign last_bit = (state == RUN) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // single 1-bit ALU slice
  assign a_i = a_sr[0];
  assign b_i = b_sr[0];

  always_comb begin
    x = a_i ^ s_q[2];
    case (s_q[1:0])
      2'b00:   y = 1'b0;
      2'b01:   y = b_i;
      2'b10:   y = ~b_i;
      default: y = 1'b1;
    endcase
    if (m_q) begin
      // S is a truth table indexed by {a,b}
      r_i  = s_q[{a_i, b_i}];
      cout = 1'b0;
    end else begin
      r_i  = x ^ y ^ c_q;
      cout = (x & y) | (x & c_q) | (y & c_q);
    end
  end

  // result enters at the MSB so bit 0 reaches position 0 after WIDTH shifts
  always_comb begin
    r_nxt      = {r_i, r_sr[WIDTH-1:1]};
    p_nxt      = p_acc;
    p_nxt[cnt] = cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      p_acc <= '0;
      s_q   <= '0;
      m_q   <= 1'b0;
      c_q   <= 1'b0;
      cnt   <= '0;
      R     <= '0;
      P     <= '0;
    end else if (accept) begin
      a_sr  <= A;
      b_sr  <= B;
      r_sr  <= '0;
      p_acc <= '0;
      s_q   <= S;
      m_q   <= M;
      c_q   <= M ? 1'b0 : Pin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_nxt;
      p_acc <= p_nxt;
      c_q   <= cout;
      cnt   <= cnt + 1'b1;
      // outputs only move on the edge entering DONE
      if (last_bit) begin
        R <= r_nxt;
        P <= p_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
module tb_serial_alu;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic [3:0]   s;
  logic         m, pin;
  logic         busy, done;
  logic [W-1:0] r, p;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;

  serial_alu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (a),
    .B    (b),
    .S    (s),
    .M    (m),
    .Pin  (pin),
    .busy (busy),
    .done (done),
    .R    (r),
    .P    (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: logic mode as a sum of minterms, arithmetic via integer adds.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [3:0] is, input logic im, input logic ipin);
    exp_t         res;
    logic [W-1:0] x, y;
    int           sum, mask;
    res.r = '0;
    res.p = '0;
    if (im) begin
      res.r = (~ia & ~ib & {W{is[0]}}) | (~ia & ib & {W{is[1]}}) |
              (ia & ~ib & {W{is[2]}})  | (ia & ib & {W{is[3]}});
    end else begin
      x = is[2] ? ~ia : ia;
      case (is[1:0])
        2'b00:   y = '0;
        2'b01:   y = ib;
        2'b10:   y = ~ib;
        default: y = '1;
      endcase
      sum   = int'(x) + int'(y) + int'(ipin);
      res.r = W'(sum);
      for (int i = 0; i < W; i++) begin
        mask       = (1 << (i + 1)) - 1;
        sum        = (int'(x) & mask) + (int'(y) & mask) + int'(ipin);
        res.p[i]   = ((sum >> (i + 1)) & 1) != 0;
      end
    end
    return res;
  endfunction

  // Present an operation in the next low phase; it is accepted on the following edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] is, input logic im, input logic ipin);
    @(negedge clk);
    a = ia; b = ib; s = is; m = im; pin = ipin;
    start = 1'b1;
    sb.push_back(model(ia, ib, is, im, ipin));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom); pin = 1'($urandom);
  endtask

  // Counts low phases after the accept edge until done; W+1 is nominal.
  task automatic wait_done(input int budget, output int cycles, output bit to);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < budget);
    to = !done;
  endtask

  task automatic pop_exp(output exp_t x, output bit ok);
    ok = sb.size() != 0;
    if (ok) x = sb.pop_front();
    else begin x.r = 'x; x.p = 'x; end
  endtask

  task automatic test_reset();
    int cyc; bit to, ok;
    rst_n = 1'b0; start = 1'b1;
    a = 4'd3; b = 4'd11; s = 4'b0001; m = 1'b0; pin = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_tests++; if (r !== '0) begin n_fail++; $display("FAIL reset_r: got %0d want 0", r); end
    n_tests++; if (p !== '0) begin n_fail++; $display("FAIL reset_p: got %b want 0", p); end
    rst_n = 1'b1;
    sb.push_back(model(4'd3, 4'd11, 4'b0001, 1'b0, 1'b0));
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(20, cyc, to);
    n_tests++; if (to || cyc != W + 1) begin n_fail++; $display("FAIL reset_latency: got %0d want %0d", cyc, W + 1); end
    pop_exp(e, ok);
    n_tests++; if (!ok || r !== e.r) begin n_fail++; $display("FAIL add_r: got %0d want %0d", r, e.r); end
    n_tests++; if (!ok || p !== e.p) begin n_fail++; $display("FAIL add_p: got %b want %b", p, e.p); end
  endtask

  task automatic test_wrap();
    int cyc; bit to, ok;
    issue(4'd15, 4'd1, 4'b0001, 1'b0, 1'b0);
    wait_done(20, cyc, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL wrap_timeout: got no done after %0d cycles", cyc); end
    pop_exp(e, ok);
    n_tests++; if (!ok || r !== e.r) begin n_fail++; $display("FAIL wrap_r: got %0d want %0d", r, e.r); end
    n_tests++; if (!ok || p !== e.p) begin n_fail++; $display("FAIL wrap_p: got %b want %b", p, e.p); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_sub();
    int cyc; bit to, ok;
    issue(4'd9, 4'd1, 4'b0010, 1'b0, 1'b1);
    wait_done(20, cyc, to);
    pop_exp(e, ok);
    n_tests++; if (to || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL sub_noborrow: got r=%0d p=%b want r=%0d p=%b", r, p, e.r, e.p); end
    issue(4'd1, 4'd9, 4'b0010, 1'b0, 1'b1);
    wait_done(20, cyc, to);
    pop_exp(e, ok);
    n_tests++; if (to || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL sub_borrow: got r=%0d p=%b want r=%0d p=%b", r, p, e.r, e.p); end
  endtask

  task automatic test_logic();
    int cyc; bit to, ok;
    issue(4'd10, 4'd2, 4'b0110, 1'b1, 1'b1);
    wait_done(20, cyc, to);
    pop_exp(e, ok);
    n_tests++; if (to || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL logic_xor: got r=%0d p=%b want r=%0d p=%b", r, p, e.r, e.p); end
    issue(4'd5, 4'd13, 4'b1001, 1'b1, 1'b1);
    wait_done(20, cyc, to);
    pop_exp(e, ok);
    n_tests++; if (to || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL logic_xnor: got r=%0d p=%b want r=%0d p=%b", r, p, e.r, e.p); end
  endtask

  task automatic test_busy_protect();
    logic [W-1:0] old_r, old_p;
    bit ok;
    old_r = r; old_p = p;
    issue(4'd6, 4'd7, 4'b0001, 1'b0, 1'b1);
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk);
      if (c <= W) begin
        n_tests++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL busy_run%0d: got busy=%b done=%b want 1 0", c, busy, done); end
        n_tests++; if (r !== old_r || p !== old_p) begin n_fail++; $display("FAIL busy_hold%0d: got r=%0d p=%b want r=%0d p=%b", c, r, p, old_r, old_p); end
      end else begin
        pop_exp(e, ok);
        n_tests++; if (done !== 1'b1 || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL busy_result: got done=%b r=%0d p=%b want 1 r=%0d p=%b", done, r, p, e.r, e.p); end
      end
      if (c == 2) begin
        start = 1'b1; a = 4'd12; b = 4'd12; s = 4'b0110; m = 1'b1; pin = 1'b0;
      end
      if (c == 3) start = 1'b0;
    end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL busy_noreissue: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit to, ok, saw_done;
    issue(4'd12, 4'd5, 4'b0010, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    n_tests++; if (r !== '0 || p !== '0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midreset_out: got r=%0d p=%b busy=%b done=%b want all 0", r, p, busy, done); end
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL midreset_nodone: got done=1 want 0"); end
    issue(4'd9, 4'd4, 4'b0011, 1'b0, 1'b0);
    wait_done(20, cyc, to);
    pop_exp(e, ok);
    n_tests++; if (to || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL midreset_next: got r=%0d p=%b want r=%0d p=%b", r, p, e.r, e.p); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to, ok;
    for (int k = 0; k < 24; k++) begin
      issue(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
      wait_done(20, cyc, to);
      pop_exp(e, ok);
      n_tests++; if (to || cyc != W + 1 || !ok || r !== e.r || p !== e.p) begin n_fail++; $display("FAIL b2b%0d: got r=%0d p=%b cyc=%0d want r=%0d p=%b cyc=%0d", k, r, p, cyc, e.r, e.p, W + 1); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; s = '0; m = 1'b0; pin = 1'b0;
    test_reset();
    test_wrap();
    test_sub();
    test_logic();
    test_busy_protect();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
